// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 datapath: control-word field positions, ALU ops,
// bus and PC source encodings.
package legv8_pkg;

  localparam int unsigned CwBsLsb  = 31;
  localparam int unsigned CwPsLsb  = 29;
  localparam int unsigned CwIl     = 28;
  localparam int unsigned CwBsel   = 27;
  localparam int unsigned CwAsrc   = 26;
  localparam int unsigned CwSl     = 25;
  localparam int unsigned CwFsLsb  = 20;
  localparam int unsigned CwC0     = 19;
  localparam int unsigned CwMw     = 16;
  localparam int unsigned CwRw     = 15;
  localparam int unsigned CwDaLsb  = 10;
  localparam int unsigned CwSaLsb  = 5;
  localparam int unsigned CwSbLsb  = 0;

  typedef enum logic [2:0] {
    OpAnd = 3'b000,
    OpOr  = 3'b001,
    OpAdd = 3'b010,
    OpXor = 3'b011,
    OpLsl = 3'b100,
    OpLsr = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    BsAlu  = 2'b00,
    BsRegB = 2'b01,
    BsMemA = 2'b10,
    BsMemB = 2'b11
  } bus_src_e;

  typedef enum logic [1:0] {
    PsHold = 2'b00,
    PsInc  = 2'b01,
    PsJmpA = 2'b10,
    PsRel  = 2'b11
  } pc_sel_e;

  localparam logic [4:0] Xzr = 5'd31;

endpackage

// File: rtl/legv8_regfile.sv
// 32x64 register file, two combinational read ports, one write port; XZR reads zero.
// Exposes the low 16 bits of R0-R7 for debug.
module legv8_regfile
  import legv8_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [4:0]       wa_i,
  input  logic [63:0]      wd_i,
  input  logic [4:0]       ra_a_i,
  input  logic [4:0]       ra_b_i,
  output logic [63:0]      rd_a_o,
  output logic [63:0]      rd_b_o,
  output logic [7:0][15:0] dbg_o
);

  logic [63:0] regs_q [32];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (wa_i != Xzr)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = (ra_a_i == Xzr) ? 64'd0 : regs_q[ra_a_i];
  assign rd_b_o = (ra_b_i == Xzr) ? 64'd0 : regs_q[ra_b_i];

  always_comb begin
    dbg_o = '0;
    for (int i = 0; i < 8; i++) begin
      dbg_o[i] = regs_q[i][15:0];
    end
  end

endmodule

// File: rtl/legv8_datapath_ts.sv
// LEGv8 64-bit datapath driven by a 40-bit control word; shares a tri-state data bus
// with external memory.
module legv8_datapath_ts
  import legv8_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [39:0] ControlWord,
  inout  wire  [63:0] data,
  output logic [31:0] address,
  input  logic [63:0] constant,
  output logic [4:0]  status,
  output logic [31:0] IR_out,
  output logic [3:0]  current_status,
  output logic [15:0] r0,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [15:0] r3,
  output logic [15:0] r4,
  output logic [15:0] r5,
  output logic [15:0] r6,
  output logic [15:0] r7
);

  bus_src_e        bs;
  pc_sel_e         ps;
  logic            il, bsel, asrc, sl, c0, rw;
  logic [4:0]      fs, da, sa, sb;
  logic [63:0]     a, b, b_op, a_alt, b_alt, result;
  logic [64:0]     sum;
  logic            flag_v, flag_c, flag_n, flag_z;
  logic [63:0]     pc_d, pc_q;
  logic [31:0]     ir_q;
  logic [3:0]      flags_q;
  logic [7:0][15:0] dbg;
  logic            unused_cw;

  assign bs   = bus_src_e'(ControlWord[CwBsLsb +: 2]);
  assign ps   = pc_sel_e'(ControlWord[CwPsLsb +: 2]);
  assign il   = ControlWord[CwIl];
  assign bsel = ControlWord[CwBsel];
  assign asrc = ControlWord[CwAsrc];
  assign sl   = ControlWord[CwSl];
  assign fs   = ControlWord[CwFsLsb +: 5];
  assign c0   = ControlWord[CwC0];
  assign rw   = ControlWord[CwRw];
  assign da   = ControlWord[CwDaLsb +: 5];
  assign sa   = ControlWord[CwSaLsb +: 5];
  assign sb   = ControlWord[CwSbLsb +: 5];
  // MW only qualifies the external memory write; the datapath has no use for it.
  assign unused_cw = ^{ControlWord[39:33], ControlWord[18:16]};

  legv8_regfile u_regfile (
    .clk_i  (clock),
    .rst_ni (reset),
    .we_i   (rw),
    .wa_i   (da),
    .wd_i   (data),
    .ra_a_i (sa),
    .ra_b_i (sb),
    .rd_a_o (a),
    .rd_b_o (b),
    .dbg_o  (dbg)
  );

  always_comb begin
    b_op   = bsel ? constant : b;
    a_alt  = fs[1] ? ~a : a;
    b_alt  = fs[0] ? ~b_op : b_op;
    sum    = {1'b0, a_alt} + {1'b0, b_alt} + {64'd0, c0};
    result = '0;
    flag_c = 1'b0;
    flag_v = 1'b0;
    case (alu_op_e'(fs[4:2]))
      OpAnd: result = a_alt & b_alt;
      OpOr:  result = a_alt | b_alt;
      OpAdd: begin
        result = sum[63:0];
        flag_c = sum[64];
        flag_v = (a_alt[63] == b_alt[63]) && (sum[63] != a_alt[63]);
      end
      OpXor: result = a_alt ^ b_alt;
      OpLsl: result = a_alt << b_op[5:0];
      OpLsr: result = a_alt >> b_op[5:0];
      default: result = '0;
    endcase
    flag_z = (result == 64'd0);
    flag_n = result[63];
  end

  assign status = {(a == 64'd0), flag_v, flag_c, flag_n, flag_z};

  // Bus is released for both memory-source encodings so memory can drive it.
  assign data = (bs == BsAlu)  ? result :
                (bs == BsRegB) ? b      : 64'bz;

  assign address = asrc ? pc_q[31:0] : result[31:0];

  always_comb begin
    pc_d = pc_q;
    case (ps)
      PsInc:   pc_d = pc_q + 64'd4;
      PsJmpA:  pc_d = a;
      PsRel:   pc_d = pc_q + constant;
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (il) ir_q <= data[31:0];
      if (sl) flags_q <= {flag_v, flag_c, flag_n, flag_z};
    end
  end

  assign IR_out         = ir_q;
  assign current_status = flags_q;
  assign r0 = dbg[0];
  assign r1 = dbg[1];
  assign r2 = dbg[2];
  assign r3 = dbg[3];
  assign r4 = dbg[4];
  assign r5 = dbg[5];
  assign r6 = dbg[6];
  assign r7 = dbg[7];

endmodule

// File: tb/tb_legv8_datapath_ts.sv
// Scoreboard bench for legv8_datapath_ts with a small word-addressed bus-side memory.
module tb_legv8_datapath_ts;

  localparam logic [63:0] FetchWord = 64'h0000_0000_8B02_0041;

  logic        clock = 1'b0;
  logic        reset;
  logic [39:0] ControlWord;
  wire  [63:0] data;
  logic [31:0] address;
  logic [63:0] constant;
  logic [4:0]  status;
  logic [31:0] IR_out;
  logic [3:0]  current_status;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;

  logic [63:0] mem [32];
  logic [63:0] mem_rd;
  logic        mem_oe;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  legv8_datapath_ts dut (
    .clock          (clock),
    .reset          (reset),
    .ControlWord    (ControlWord),
    .data           (data),
    .address        (address),
    .constant       (constant),
    .status         (status),
    .IR_out         (IR_out),
    .current_status (current_status),
    .r0             (r0),
    .r1             (r1),
    .r2             (r2),
    .r3             (r3),
    .r4             (r4),
    .r5             (r5),
    .r6             (r6),
    .r7             (r7)
  );

  always #5 clock = ~clock;

  // Memory drives the bus whenever the datapath releases it (BS[1] set).
  assign mem_oe = ControlWord[32];
  assign mem_rd = (address[7:3] == 5'd0) ? FetchWord : mem[address[7:3]];
  assign data   = mem_oe ? mem_rd : 64'bz;

  always @(posedge clock) begin
    if (ControlWord[16] && (ControlWord[32:31] == 2'b01)) mem[address[7:3]] <= data;
  end

  function automatic logic [39:0] mk(input logic [1:0] bs, input logic [1:0] ps,
                                     input logic il, input logic bsel, input logic asrc,
                                     input logic sl, input logic [4:0] fs, input logic c0,
                                     input logic mw, input logic rw, input logic [4:0] da,
                                     input logic [4:0] sa, input logic [4:0] sb);
    logic [39:0] w;
    w = '0;
    w[32:31] = bs;   w[30:29] = ps;   w[28] = il;   w[27] = bsel;
    w[26] = asrc;    w[25] = sl;      w[24:20] = fs; w[19] = c0;
    w[16] = mw;      w[15] = rw;      w[14:10] = da; w[9:5] = sa;
    w[4:0] = sb;
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
  endtask

  task automatic sb_push(input string tag, input logic [63:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_check(input logic [63:0] got);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty: got 0x%016h expected <none>", got);
    end else begin
      it = sb_q.pop_front();
      check_eq(it.tag, got, it.exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    constant    = '0;
    ControlWord = mk(2'b10, 2'b00, 0, 0, 1, 0, 5'b00000, 0, 0, 0, 5'd0, 5'd31, 5'd31);
    repeat (2) @(posedge clock);
    #1;
    sb_push("rst_pc", 64'd0);      sb_check(64'(address));
    sb_push("rst_ir", 64'd0);      sb_check(64'(IR_out));
    sb_push("rst_flags", 64'd0);   sb_check(64'(current_status));
    sb_push("rst_r0", 64'd0);      sb_check(64'(r0));
    sb_push("rst_r7", 64'd0);      sb_check(64'(r7));
    reset = 1'b1;

    // R0 <= XZR | 24
    constant    = 64'd24;
    ControlWord = mk(2'b00, 2'b00, 0, 1, 0, 0, 5'b00100, 0, 0, 1, 5'd0, 5'd31, 5'd0);
    sb_push("or_bus", 64'd24);
    sb_push("or_r0", 64'h18);
    #3 sb_check(data);
    tick();
    sb_check(64'(r0));

    // R1 <= XZR - R0, flags loaded
    ControlWord = mk(2'b00, 2'b00, 0, 0, 0, 1, 5'b01001, 1, 0, 1, 5'd1, 5'd31, 5'd0);
    sb_push("sub_status", 64'b10010);
    sb_push("sub_r1", 64'hFFE8);
    sb_push("sub_flags", 64'b0010);
    #3 sb_check(64'(status));
    tick();
    sb_check(64'(r1));
    sb_check(64'(current_status));

    // Store R1 to address 24
    ControlWord = mk(2'b01, 2'b00, 0, 1, 0, 0, 5'b00100, 0, 1, 0, 5'd0, 5'd31, 5'd1);
    sb_push("st_addr", 64'd24);
    sb_push("st_bus", 64'hFFFF_FFFF_FFFF_FFE8);
    sb_push("st_mem", 64'hFFFF_FFFF_FFFF_FFE8);
    #3 sb_check(64'(address));
    sb_check(data);
    tick();
    sb_check(mem[3]);

    // R1 <= R0 & R1
    ControlWord = mk(2'b00, 2'b00, 0, 0, 0, 0, 5'b00000, 0, 0, 1, 5'd1, 5'd0, 5'd1);
    sb_push("and_r1", 64'h0008);
    tick();
    sb_check(64'(r1));

    // Load R2 from address 24 with the datapath off the bus
    ControlWord = mk(2'b11, 2'b00, 0, 1, 0, 0, 5'b00100, 0, 0, 1, 5'd2, 5'd31, 5'd0);
    sb_push("ld_bus", 64'hFFFF_FFFF_FFFF_FFE8);
    sb_push("ld_r2", 64'hFFE8);
    #3 sb_check(data);
    tick();
    sb_check(64'(r2));

    // R3 <= R0 << 4, R4 <= R1 >> 3, R5 <= R0 ^ 0xFF
    constant    = 64'd4;
    ControlWord = mk(2'b00, 2'b00, 0, 1, 0, 0, 5'b10000, 0, 0, 1, 5'd3, 5'd0, 5'd0);
    sb_push("lsl_r3", 64'h0180);
    tick();
    sb_check(64'(r3));
    constant    = 64'd3;
    ControlWord = mk(2'b00, 2'b00, 0, 1, 0, 0, 5'b10100, 0, 0, 1, 5'd4, 5'd1, 5'd0);
    sb_push("lsr_r4", 64'h0001);
    tick();
    sb_check(64'(r4));
    constant    = 64'hFF;
    ControlWord = mk(2'b00, 2'b00, 0, 1, 0, 0, 5'b01100, 0, 0, 1, 5'd5, 5'd0, 5'd0);
    sb_push("xor_r5", 64'h00E7);
    tick();
    sb_check(64'(r5));

    // Write to XZR is dropped; reading it back yields zero
    constant    = 64'h55;
    ControlWord = mk(2'b00, 2'b00, 0, 1, 0, 0, 5'b00100, 0, 0, 1, 5'd31, 5'd31, 5'd0);
    tick();
    constant    = 64'd0;
    ControlWord = mk(2'b00, 2'b00, 0, 0, 0, 0, 5'b00100, 0, 0, 0, 5'd0, 5'd31, 5'd31);
    sb_push("xzr_read", 64'd0);
    #3 sb_check(data);
    tick();

    // Signed overflow: R6 = 0x7FFF..FF, then R6 + 1 with flags loaded
    constant    = 64'h7FFF_FFFF_FFFF_FFFF;
    ControlWord = mk(2'b00, 2'b00, 0, 1, 0, 0, 5'b00100, 0, 0, 1, 5'd6, 5'd31, 5'd0);
    sb_push("max_r6", 64'hFFFF);
    tick();
    sb_check(64'(r6));
    constant    = 64'd1;
    ControlWord = mk(2'b00, 2'b00, 0, 1, 0, 1, 5'b01000, 0, 0, 0, 5'd0, 5'd6, 5'd0);
    sb_push("ovf_status", 64'b01010);
    sb_push("ovf_flags", 64'b1010);
    #3 sb_check(64'(status));
    tick();
    sb_check(64'(current_status));

    // Instruction fetch at PC=0, then PC+4
    ControlWord = mk(2'b10, 2'b00, 1, 0, 1, 0, 5'b00000, 0, 0, 0, 5'd0, 5'd31, 5'd31);
    sb_push("fetch_addr", 64'd0);
    sb_push("fetch_bus", FetchWord);
    sb_push("fetch_ir", 64'h8B02_0041);
    #3 sb_check(64'(address));
    sb_check(data);
    tick();
    sb_check(64'(IR_out));
    ControlWord = mk(2'b10, 2'b01, 0, 0, 1, 0, 5'b00000, 0, 0, 0, 5'd0, 5'd31, 5'd31);
    sb_push("pc_inc", 64'd4);
    tick();
    sb_check(64'(address));

    // Asynchronous reset mid-cycle
    ControlWord = mk(2'b10, 2'b00, 0, 0, 1, 0, 5'b00000, 0, 0, 0, 5'd0, 5'd31, 5'd31);
    #2 reset = 1'b0;
    sb_push("arst_pc", 64'd0);
    sb_push("arst_ir", 64'd0);
    sb_push("arst_flags", 64'd0);
    sb_push("arst_r0", 64'd0);
    sb_push("arst_r1", 64'd0);
    sb_push("arst_r2", 64'd0);
    sb_push("arst_r5", 64'd0);
    #1 sb_check(64'(address));
    sb_check(64'(IR_out));
    sb_check(64'(current_status));
    sb_check(64'(r0));
    sb_check(64'(r1));
    sb_check(64'(r2));
    sb_check(64'(r5));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/legv8_datapath_ts.md
Name: legv8_datapath_ts

Overview:
- 64-bit LEGv8 datapath controlled entirely by a 40-bit control word from the external control unit.
- Contains a 32x64 register file (R31 reads as zero), ALU, status register, program counter and instruction register.
- Talks to external memory over a shared bidirectional 64-bit tri-state data bus and a 32-bit address bus.
- Exposes debug taps for IR, flags and R0-R7.

Parameters:
- none (all widths fixed)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ControlWord  in  40  control fields (see Behaviour)
- data  inout  64  shared tri-state data bus
- address  out  32  memory address
- constant  in  64  immediate operand from control unit
- status  out  5  combinational {RegA_zero, V, C, N, Z}
- IR_out  out  32  instruction register contents
- current_status  out  4  registered flags {V, C, N, Z}
- r0..r7  out  16 each  low 16 bits of R0..R7

Behaviour:
- Control word fields, MSB first:
  - [39:34]: reserved, ignored.
  - [33]: reserved.
  - [32:31] BS, bus source: 00 ALU drives data; 01 register B drives data; 10/11 datapath releases bus (memory drives).
  - [30:29] PS, PC function: 00 hold; 01 PC+4; 10 PC<=A; 11 PC<=PC+constant.
  - [28] IL: IR load.
  - [27] BSEL: 1 = B operand is constant, 0 = register B.
  - [26] ASRC: 1 = address=PC[31:0], 0 = address=ALU[31:0].
  - [25] SL: status load.
  - [24:20] FS.
  - [19] C0: carry-in.
  - [18:17]: reserved.
  - [16] MW: memory write strobe, datapath-side only; meaningful only with BS=01.
  - [15] RW: register write.
  - [14:10] DA, [9:5] SA, [4:0] SB.
- Register file:
  - A=R[SA], B=R[SB], read combinationally; R31 always reads 0.
  - On rising clock with RW=1 and DA!=31: R[DA] <= data bus.
  - A write and a read of the same register in one cycle returns the old value.
- ALU:
  - A' = FS[1] ? ~A : A; B' = FS[0] ? ~Bop : Bop.
  - FS[4:2]: 000 AND, 001 OR, 010 ADD (A'+B'+C0), 011 XOR, 100 LSL by Bop[5:0], 101 LSR by Bop[5:0]; others give 0.
  - Flags: Z = result==0; N = result[63]; C = adder carry-out, V = signed overflow (both 0 for non-ADD ops).
  - status[4] = (A==0).
- Tri-state bus: data = Z whenever BS is 10 or 11.
- IR: on clock with IL=1, IR <= data[31:0].
- Status register: on clock with SL=1, current_status <= {V,C,N,Z}.
- PC: 64-bit, updated on clock per PS.
- Reset (reset=0, asynchronous): all registers, PC, IR and current_status clear to 0; the bus is still driven per BS combinationally.
- Wrap-around: PC and adder wrap mod 2^64; shifts of 64 or more are impossible because the amount is 6 bits.

Decomposition:
- Shared package legv8_pkg:
  - control-word field index constants;
  - FS op codes;
  - BS and PS encodings;
  - XZR index 31.
- One sub-module: legv8_regfile (32x64, two read ports, one write port, async reset, R0-R7 debug taps).
- ALU, PC, IR and bus logic stay inline.

Test Plan:
- Reset low then high, constant=24, R0<=R31|K (FS=00100, BSEL=1, RW=1, DA=0, SA=31) -> r0=0x0018, data bus=24 during cycle.
- R1<=R31-R0 (FS=01001, C0=1, SA=31, SB=0, DA=1) -> r1=0xFFE8, status N=1, C=0, Z=0.
- Store: BS=01, BSEL=1, MW=1, SA=31, SB=1, constant=24 -> address=24, data=0xFFFFFFFFFFFFFFE8; bench memory captures it.
- R1<=R0&R1 (FS=00000, SA=0, SB=1, DA=1) -> r1=0x0008.
- Load R2: BS=11, BSEL=1, SA=31, DA=2, RW=1; bench memory drives stored word -> r2=0xFFE8, datapath not driving data.
- Fetch: ASRC=1, BS=10, IL=1, memory returns 0x8B020041 at address PC=0 -> IR_out=0x8B020041. Then PS=01 -> PC=4, address=4. Then reset=0 mid-run -> PC, IR, r0-r7, current_status all 0 immediately.
